bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter, one bit per clock
module bin_to_bcd_seq #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // Scratch holds every decimal digit 2^WIDTH-1 can need, and at least DIGITS digits.
  localparam int SD = (WIDTH * 30103 + 99999) / 100000;
  localparam int ND = (SD > DIGITS) ? SD : DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d, bin_sh;
  logic [4*ND-1:0]     scr_q, scr_d, scr_adj, scr_sh;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, result;
  logic                ovf_q, ovf_d, result_ovf;
  logic                last_iter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble step: correct digits >= 5, then shift the combined register left.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < ND; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    {scr_sh, bin_sh} = {scr_adj, bin_q} << 1;

    result_ovf = 1'b0;
    for (int i = DIGITS; i < ND; i++) begin
      if (scr_sh[4*i +: 4] != 4'd0) result_ovf = 1'b1;
    end
    result = result_ovf ? {DIGITS{4'h9}} : scr_sh[4*DIGITS-1:0];
  end

  always_comb begin
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d = bin;
          scr_d = '0;
          cnt_d = '0;
        end
      end
      S_SHIFT: begin
        bin_d = bin_sh;
        scr_d = scr_sh;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          bcd_d = result;
          ovf_d = result_ovf;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_SHIFT);
    done     = (state_q == S_DONE);
    BCD      = bcd_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed and randomized checks of bin_to_bcd_seq against a decimal model
module tb_bin_to_bcd_seq;
  localparam int WIDTH  = 20;
  localparam int DIGITS = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic [4*DIGITS-1:0] BCD;
  logic                busy;
  logic                done;
  logic                overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .BCD      (BCD),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  function automatic logic [4*DIGITS-1:0] ref_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    longint unsigned lim = 1;
    longint unsigned x   = v;
    for (int d = 0; d < DIGITS; d++) lim = lim * 10;
    for (int d = 0; d < DIGITS; d++) begin
      if (v >= lim) r[4*d +: 4] = 4'd9;
      else begin
        r[4*d +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v);
    longint unsigned lim = 1;
    for (int d = 0; d < DIGITS; d++) lim = lim * 10;
    return (v >= lim);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic convert(input logic [WIDTH-1:0] v, input string tag);
    logic [4*DIGITS-1:0] held;
    logic                held_ovf;
    int                  lat;
    held     = BCD;
    held_ovf = overflow;
    lat      = 0;
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = WIDTH'($urandom);
    while (!done && lat < 40) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_hold"}, {39'd0, overflow, BCD}, {39'd0, held_ovf, held});
      tick();
      lat++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    chk({tag, "_bcd"}, 64'(BCD), 64'(ref_bcd(64'(v))));
    chk({tag, "_ovf"}, 64'(overflow), 64'(ref_ovf(64'(v))));
    tick();
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int                  ndone;
    int                  last_done;
    logic [4*DIGITS-1:0] got;
    logic [WIDTH-1:0]    v;

    reset = 1'b1;
    start = 1'b1;
    bin   = WIDTH'(12345);
    tick();
    tick();
    chk("rst_bcd", 64'(BCD), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    start = 1'b0;

    convert(WIDTH'(0), "zero");
    convert(WIDTH'(123456), "d123456");
    convert(WIDTH'(999999), "d999999");
    convert(WIDTH'(9), "d9");
    convert(WIDTH'(1000000), "ovf_1e6");
    convert({WIDTH{1'b1}}, "ovf_max");
    convert(WIDTH'(5), "d5");
    for (int i = 0; i < 12; i++) begin
      convert(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), "rand");
    end

    // Restart attempts and bin changes mid-conversion must be ignored.
    v     = WIDTH'(314159);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    bin   = WIDTH'(777777);
    repeat (3) tick();
    start = 1'b0;
    bin   = '0;
    ndone = 0;
    got   = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        got = BCD;
      end
      tick();
    end
    chk("midshift_ndone", 64'(ndone), 64'd1);
    chk("midshift_bcd", 64'(got), 64'(ref_bcd(64'(v))));

    // Abort at iteration 10 with a nonzero previous result on BCD.
    bin   = WIDTH'(55555);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("abort_bcd", 64'(BCD), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_bcd_stays", 64'(BCD), 64'd0);
    convert(WIDTH'(55555), "after_abort");

    // Start held high: bin steps 0..15, one result every WIDTH+2 cycles.
    bin   = '0;
    start = 1'b1;
    tick();
    bin       = WIDTH'(1);
    last_done = 0;
    for (int j = 0; j < 16; j++) begin
      int n;
      n = 0;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      chk("b2b_done", 64'(done), 64'd1);
      chk("b2b_bcd", 64'(BCD), 64'(ref_bcd(64'(j))));
      chk("b2b_ovf", 64'(overflow), 64'd0);
      if (j > 0) chk("b2b_period", 64'(cyc - last_done), 64'(WIDTH + 2));
      last_done = cyc;
      if (j == 15) start = 1'b0;
      tick();
      tick();
      bin = WIDTH'(j + 2);
    end
    repeat (30) tick();
    chk("b2b_stopped", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
